// File: rtl/pong_game_ctl.sv
// Pong frame-rate game controller: serve/play/score/game-over sequencing.
// Ball motion, wall bounces and paddle hits are evaluated once per frame_tick.
module pong_game_ctl #(
    parameter int SCREEN_W    = 1024,
    parameter int SCREEN_H    = 768,
    parameter int PAD_HALF    = 100,
    parameter int PAD_W       = 10,
    parameter int BALL_HALF   = 5,
    parameter int BALL_SPEED  = 4,
    parameter int SERVE_DELAY = 60,
    parameter int WIN_SCORE   = 9
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic [10:0] left_palette_pos,
    input  logic [10:0] right_palette_pos,
    output logic [10:0] ball_xpos,
    output logic [10:0] ball_ypos,
    output logic [7:0]  score,
    output logic        game_over
);

    localparam int CW = $clog2(SERVE_DELAY + 1);

    localparam logic [11:0] C_X    = 12'(SCREEN_W / 2);
    localparam logic [11:0] C_Y    = 12'(SCREEN_H / 2);
    localparam logic [11:0] SPD    = 12'(BALL_SPEED);
    localparam logic [11:0] L_EDGE = 12'(PAD_W + BALL_HALF);
    localparam logic [11:0] R_EDGE = 12'(SCREEN_W - PAD_W - BALL_HALF);
    localparam logic [11:0] Y_BOT  = 12'(SCREEN_H - 1 - BALL_HALF);
    localparam logic [11:0] Y_TOP  = 12'(BALL_HALF);
    localparam logic [11:0] HIT_R  = 12'(PAD_HALF + BALL_HALF);
    localparam logic [CW-1:0] CNT_LD = CW'(SERVE_DELAY);
    localparam logic [3:0]  WIN    = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_SCORED,
        S_OVER
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [11:0]   r_x, r_y, w_x_nxt, w_y_nxt;
    logic          r_dx, r_dy, w_dx_nxt, w_dy_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]    r_sl, r_sr, w_sl_nxt, w_sr_nxt;
    logic          r_lsc, w_lsc_nxt;
    logic          r_go, w_go_nxt;

    logic [10:0]        w_pad;
    logic signed [11:0] w_diff;
    logic [11:0]        w_adiff;
    logic               w_hit, w_edge, w_bot, w_top;
    logic [3:0]         w_old, w_nib;

    // dir_x=1 means moving right, so the paddle being approached is the right one
    assign w_pad   = r_dx ? right_palette_pos : left_palette_pos;
    assign w_diff  = $signed(r_y) - $signed({1'b0, w_pad});
    assign w_adiff = w_diff[11] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_hit   = w_adiff < HIT_R;
    assign w_edge  = r_dx ? (r_x + SPD >= R_EDGE) : (r_x - SPD <= L_EDGE);
    assign w_bot   = r_dy && (r_y + SPD >= Y_BOT);
    assign w_top   = !r_dy && (r_y < Y_TOP + SPD);
    assign w_old   = r_lsc ? r_sl : r_sr;
    assign w_nib   = (w_old == 4'd9) ? 4'd9 : w_old + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_dx_nxt    = r_dx;
        w_dy_nxt    = r_dy;
        w_cnt_nxt   = r_cnt;
        w_sl_nxt    = r_sl;
        w_sr_nxt    = r_sr;
        w_lsc_nxt   = r_lsc;
        w_go_nxt    = r_go;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SERVE;
                    w_cnt_nxt   = CNT_LD;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
                    else             w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    if (w_edge && !w_hit) begin
                        w_state_nxt = S_SCORED;
                        w_lsc_nxt   = r_dx;
                        w_x_nxt     = C_X;
                        w_y_nxt     = C_Y;
                    end else begin
                        if (w_edge) begin
                            w_x_nxt  = r_dx ? R_EDGE : L_EDGE;
                            w_dx_nxt = !r_dx;
                        end else begin
                            w_x_nxt  = r_dx ? r_x + SPD : r_x - SPD;
                        end
                        if (w_bot) begin
                            w_y_nxt  = Y_BOT;
                            w_dy_nxt = 1'b0;
                        end else if (w_top) begin
                            w_y_nxt  = Y_TOP;
                            w_dy_nxt = 1'b1;
                        end else begin
                            w_y_nxt  = r_dy ? r_y + SPD : r_y - SPD;
                        end
                    end
                end
            end
            S_SCORED: begin
                if (r_lsc) w_sl_nxt = w_nib;
                else       w_sr_nxt = w_nib;
                w_x_nxt = C_X;
                w_y_nxt = C_Y;
                if (w_nib == WIN) begin
                    w_state_nxt = S_OVER;
                    w_go_nxt    = 1'b1;
                end else begin
                    // serve heads toward the player who just conceded
                    w_dx_nxt    = r_lsc;
                    w_cnt_nxt   = CNT_LD;
                    w_state_nxt = S_SERVE;
                end
            end
            S_OVER: begin
                if (start) begin
                    w_sl_nxt    = 4'd0;
                    w_sr_nxt    = 4'd0;
                    w_go_nxt    = 1'b0;
                    w_cnt_nxt   = CNT_LD;
                    w_state_nxt = S_SERVE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= C_X;
            r_y     <= C_Y;
            r_dx    <= 1'b1;
            r_dy    <= 1'b1;
            r_cnt   <= '0;
            r_sl    <= 4'd0;
            r_sr    <= 4'd0;
            r_lsc   <= 1'b0;
            r_go    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_dx    <= w_dx_nxt;
            r_dy    <= w_dy_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sl    <= w_sl_nxt;
            r_sr    <= w_sr_nxt;
            r_lsc   <= w_lsc_nxt;
            r_go    <= w_go_nxt;
        end
    end

    assign ball_xpos = r_x[10:0];
    assign ball_ypos = r_y[10:0];
    assign score     = {r_sl, r_sr};
    assign game_over = r_go;

endmodule

// File: tb/tb_pong_game_ctl.sv
// Bench for pong_game_ctl: directed table, rally corner cases, random play
// compared against a game-level reference model.
module tb_pong_game_ctl;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic [10:0] lpos = 11'd0;
    logic [10:0] rpos = 11'd0;
    logic [10:0] ball_xpos, ball_ypos;
    logic [7:0]  score;
    logic        game_over;

    int vectors = 0;
    int miscompares = 0;

    // reference model: ball position/velocity in pixels, phase of the game
    localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_SCORED = 3, P_OVER = 4;
    int mx, my, mvx, mvy, mls, mrs, mph, mcnt;
    bit mlsc;

    always #5 pclk = ~pclk;

    pong_game_ctl dut (
        .pclk(pclk),
        .rst(rst),
        .frame_tick(frame_tick),
        .start(start),
        .left_palette_pos(lpos),
        .right_palette_pos(rpos),
        .ball_xpos(ball_xpos),
        .ball_ypos(ball_ypos),
        .score(score),
        .game_over(game_over)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic model(input bit r, input bit t, input bit s,
                         input int lp, input int rp);
        int nx, ny, d;
        bit miss;
        if (r) begin
            mx = 512; my = 384; mvx = 4; mvy = 4;
            mls = 0; mrs = 0; mph = P_IDLE; mcnt = 0; mlsc = 0;
            return;
        end
        case (mph)
            P_IDLE: if (s) begin mph = P_SERVE; mcnt = 60; end
            P_SERVE: if (t) begin
                if (mcnt > 0) mcnt--;
                else mph = P_PLAY;
            end
            P_PLAY: if (t) begin
                nx = mx + mvx;
                miss = 0;
                if (mvx < 0 && nx <= 15) begin
                    d = my - lp; if (d < 0) d = -d;
                    if (d < 105) begin nx = 15; mvx = 4; end
                    else miss = 1;
                end else if (mvx > 0 && nx >= 1009) begin
                    d = my - rp; if (d < 0) d = -d;
                    if (d < 105) begin nx = 1009; mvx = -4; end
                    else miss = 1;
                end
                if (miss) begin
                    mlsc = (mvx > 0);
                    mx = 512; my = 384; mph = P_SCORED;
                end else begin
                    ny = my + mvy;
                    if (mvy > 0 && ny + 5 >= 767) begin ny = 762; mvy = -4; end
                    else if (mvy < 0 && my < 9) begin ny = 5; mvy = 4; end
                    mx = nx; my = ny;
                end
            end
            P_SCORED: begin
                if (mlsc) mls = (mls < 9) ? mls + 1 : 9;
                else      mrs = (mrs < 9) ? mrs + 1 : 9;
                if ((mlsc ? mls : mrs) == 9) mph = P_OVER;
                else begin
                    mvx = mlsc ? 4 : -4;
                    mcnt = 60; mph = P_SERVE;
                end
            end
            P_OVER: if (s) begin mls = 0; mrs = 0; mcnt = 60; mph = P_SERVE; end
            default: ;
        endcase
    endtask

    task automatic cyc(input bit r, input bit t, input bit s,
                       input int lp, input int rp);
        rst = r; frame_tick = t; start = s;
        lpos = 11'(lp); rpos = 11'(rp);
        model(r, t, s, lp, rp);
        @(posedge pclk);
        #1;
        vectors++;
        if (int'(ball_xpos) != mx || int'(ball_ypos) != my ||
            int'(score) != mls * 16 + mrs || game_over != (mph == P_OVER)) begin
            miscompares++;
            $display("FAIL model @%0t: got x=%0d y=%0d score=%h go=%0b, expected x=%0d y=%0d score=%h go=%0b",
                     $time, ball_xpos, ball_ypos, score, game_over,
                     mx, my, mls * 16 + mrs, mph == P_OVER);
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: condition not reached within budget", name);
    endtask

    task automatic frame(input bit s, input int lp, input int rp);
        cyc(1'b0, 1'b1, s, lp, rp);
        cyc(1'b0, 1'b0, 1'b0, lp, rp);
    endtask

    typedef struct {
        bit r, t, s;
        int ex, ey, esc, ego;
    } vec_t;

    vec_t tbl[7];
    int g;

    initial begin
        tbl[0] = '{1, 0, 0, 512, 384, 0, 0};
        tbl[1] = '{1, 1, 1, 512, 384, 0, 0};
        tbl[2] = '{0, 1, 0, 512, 384, 0, 0};
        tbl[3] = '{0, 0, 0, 512, 384, 0, 0};
        tbl[4] = '{0, 1, 0, 512, 384, 0, 0};
        tbl[5] = '{0, 1, 0, 512, 384, 0, 0};
        tbl[6] = '{0, 0, 1, 512, 384, 0, 0};
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].r, tbl[i].t, tbl[i].s, 300, 300);
            chk("tbl_x", int'(ball_xpos), tbl[i].ex);
            chk("tbl_y", int'(ball_ypos), tbl[i].ey);
            chk("tbl_score", int'(score), tbl[i].esc);
            chk("tbl_go", int'(game_over), tbl[i].ego);
        end

        // serve: 60 decrements plus the entering tick hold the ball
        for (int i = 0; i < 61; i++) begin
            frame(1'b0, 300, 300);
            chk("serve_hold_x", int'(ball_xpos), 512);
        end
        cyc(1'b0, 1'b1, 1'b0, 384, 384);
        chk("first_move_x", int'(ball_xpos), 516);
        chk("first_move_y", int'(ball_ypos), 388);
        cyc(1'b0, 1'b0, 1'b0, 384, 384);
        chk("hold_between_ticks", int'(ball_xpos), 516);

        g = 0;
        while (!(my == 760 && mvy > 0) && g < 3000) begin frame(0, my, my); g++; end
        if (g >= 3000) timeout("reach_y760");
        frame(0, my, my);
        chk("bottom_bounce", int'(ball_ypos), 762);
        frame(0, my, my);
        chk("after_bottom", int'(ball_ypos), 758);

        g = 0;
        while (!(my < 9 && mvy < 0) && g < 3000) begin frame(0, my, my); g++; end
        if (g >= 3000) timeout("reach_top");
        frame(0, my, my);
        chk("top_bounce", int'(ball_ypos), 5);
        frame(0, my, my);
        chk("after_top", int'(ball_ypos), 9);

        g = 0;
        while (!(mvx < 0 && mx - 4 <= 15) && g < 3000) begin frame(0, my, my); g++; end
        if (g >= 3000) timeout("reach_left_1");
        frame(0, my + 50, my);
        chk("left_hit_x", int'(ball_xpos), 15);
        frame(0, my, my);
        chk("left_rebound_x", int'(ball_xpos), 19);

        g = 0;
        while (!(mvx < 0 && mx - 4 <= 15) && g < 3000) begin frame(0, my, my); g++; end
        if (g >= 3000) timeout("reach_left_2");
        frame(0, my + 300, my);
        chk("left_miss_score", int'(score), 8'h01);
        chk("left_miss_x", int'(ball_xpos), 512);
        chk("left_miss_y", int'(ball_ypos), 384);
        for (int i = 0; i < 61; i++) frame(0, 300, 300);
        cyc(1'b0, 1'b1, 1'b0, 300, 300);
        chk("serve_left_x", int'(ball_xpos), 508);
        cyc(1'b0, 1'b0, 1'b0, 300, 300);

        for (int i = 0; i < 20; i++) frame(0, my, my);
        cyc(1'b1, 1'b1, 1'b0, 300, 300);
        chk("midreset_x", int'(ball_xpos), 512);
        chk("midreset_y", int'(ball_ypos), 384);
        chk("midreset_score", int'(score), 0);
        for (int i = 0; i < 3; i++) frame(0, 300, 300);
        chk("idle_no_move", int'(ball_xpos), 512);

        // left wins: right paddle parked far from every ball position
        cyc(1'b0, 1'b0, 1'b1, 300, 300);
        g = 0;
        while (!(mls == 8 && mph == P_SERVE) && g < 5000) begin frame(0, my, 2047); g++; end
        if (g >= 5000) timeout("reach_8_0");
        chk("score_80", int'(score), 8'h80);
        g = 0;
        while (mph != P_OVER && g < 1000) begin frame(0, my, 2047); g++; end
        if (g >= 1000) timeout("reach_game_over");
        chk("score_90", int'(score), 8'h90);
        chk("game_over_set", int'(game_over), 1);
        for (int i = 0; i < 5; i++) begin
            frame(0, 300, 300);
            chk("over_hold_x", int'(ball_xpos), 512);
            chk("over_hold_y", int'(ball_ypos), 384);
        end
        cyc(1'b0, 1'b0, 1'b1, 300, 300);
        chk("restart_score", int'(score), 0);
        chk("restart_go", int'(game_over), 0);
        for (int i = 0; i < 62; i++) frame(0, my, my);

        // random play against the model
        for (int i = 0; i < 6000; i++) begin
            int lp, rp;
            bit r, t, s;
            r = ($urandom_range(0, 799) == 0);
            t = ($urandom_range(0, 2) == 0);
            s = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) lp = int'($urandom_range(0, 2047));
            else lp = my + int'($urandom_range(0, 260)) - 130;
            if ($urandom_range(0, 3) == 0) rp = int'($urandom_range(0, 2047));
            else rp = my + int'($urandom_range(0, 260)) - 130;
            if (lp < 0) lp = 0;
            if (rp < 0) rp = 0;
            cyc(r, t, s, lp, rp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
